cdb_arbiter: RTL and testbench

- Produces the common data bus (CDB) broadcast that reservation stations, the ROB and the physical register file consume for wakeup and writeback.
- Accepts completed results from N_SRC execution units, each with a small per-source FIFO.
- Grants one result per cycle using round-robin arbitration and drives a registered CDB packet.
- Per-source ready signals form the EU-side backpressure. Issue logic folds these into each reservation station's `i_eu_ready`.

---
 rtl/cdb_pkg.sv | 22 ++
 rtl/cdb_arbiter_wb_fifo.sv | 77 +++++++
 rtl/cdb_arbiter.sv | 131 +++++++++++++
 tb/tb_cdb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus (CDB) writeback path.
// Contents:
//   PREG_WIDTH, ROB_WIDTH, DATA_WIDTH - payload field widths
//   SRC_ALU, SRC_BR, SRC_LSU          - result source indices (arbiter port order)
//   cdb_pkt_t                         - one completed result {prd, rob_tag, data}
package cdb_pkg;

    localparam int PREG_WIDTH = 7;
    localparam int ROB_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_BR  = 1;
    localparam int SRC_LSU = 2;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  rob_tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// wb_fifo: small per-source writeback FIFO holding cdb_pkt_t entries.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   i_flush        - drop all buffered entries (same effect as reset)
//   i_push         - write i_push_pkt (ignored when full or flushing)
//   i_push_pkt     - packet to write
//   i_pop          - retire head entry (ignored when empty or flushing)
//   o_head         - current head entry (valid when o_not_empty)
//   o_count        - number of buffered entries (registered)
//   o_not_full     - count != DEPTH
//   o_not_empty    - count != 0
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  cdb_pkt_t      i_push_pkt,
    input  logic          i_pop,
    output cdb_pkt_t      o_head,
    output logic [CW-1:0] o_count,
    output logic          o_not_full,
    output logic          o_not_empty
);

    localparam int PW = $clog2(DEPTH);

    cdb_pkt_t      r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_not_full  = (r_count != CW'(DEPTH));
    assign o_not_empty = (r_count != '0);
    assign o_count     = r_count;
    assign o_head      = r_mem[r_rd_ptr];

    assign w_do_push = i_push && o_not_full;
    assign w_do_pop  = i_pop && o_not_empty;

    // Storage needs no reset: the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Push and pop together leave the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects completed results from N_SRC execution units, each
// through its own wb_fifo, and broadcasts one per cycle on a registered CDB.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_src_valid[i]      - source i presents a result
//   i_src_prd/rob_tag/data - flattened per-source payload, slice i
//   o_src_ready[i]      - source i FIFO can accept (registered count only)
//   o_cdb_valid         - CDB broadcast valid
//   o_cdb_prd/rob_tag/data - broadcast payload (held when not valid)
//   o_cdb_rf_we         - regfile write enable, valid && prd != 0
//   branch_mispredict   - flush all buffered results; rr pointer holds
// Handshake: a source transfers a result on a cycle where i_src_valid[i] and
// o_src_ready[i] are both high at the clock edge; otherwise it must hold it.
// o_src_ready never depends on i_src_valid or on a same-cycle grant.
module cdb_arbiter #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int N_SRC      = 3,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           i_src_valid,
    input  logic [N_SRC*PREG_WIDTH-1:0] i_src_prd,
    input  logic [N_SRC*ROB_WIDTH-1:0] i_src_rob_tag,
    input  logic [N_SRC*32-1:0]        i_src_data,
    output logic [N_SRC-1:0]           o_src_ready,
    output logic                       o_cdb_valid,
    output logic [PREG_WIDTH-1:0]      o_cdb_prd,
    output logic [ROB_WIDTH-1:0]       o_cdb_rob_tag,
    output logic [31:0]                o_cdb_data,
    output logic                       o_cdb_rf_we,
    input  logic                       branch_mispredict
);

    import cdb_pkg::*;

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RRW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    cdb_pkt_t         w_push_pkt [N_SRC];
    cdb_pkt_t         w_head     [N_SRC];
    logic [CW-1:0]    w_count    [N_SRC];
    logic [N_SRC-1:0] w_not_full;
    logic [N_SRC-1:0] w_not_empty;
    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_pop;

    logic             w_gnt_valid;
    logic [RRW-1:0]   w_gnt_idx;
    logic [RRW:0]     w_cand_sum;
    logic [RRW-1:0]   w_rr_next;
    cdb_pkt_t         w_gnt_pkt;

    logic             r_cdb_valid;
    cdb_pkt_t         r_cdb_pkt;
    logic [RRW-1:0]   r_rr_ptr;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_push_pkt[gi].prd     = i_src_prd[gi*PREG_WIDTH +: PREG_WIDTH];
        assign w_push_pkt[gi].rob_tag = i_src_rob_tag[gi*ROB_WIDTH +: ROB_WIDTH];
        assign w_push_pkt[gi].data    = i_src_data[gi*32 +: 32];

        // Ready comes from the registered count: a same-cycle pop earns no credit.
        assign o_src_ready[gi] = (w_count[gi] != CW'(DEPTH));
        assign w_push[gi]      = i_src_valid[gi] && w_not_full[gi];
        assign w_pop[gi]       = w_gnt_valid && (w_gnt_idx == RRW'(gi));

        wb_fifo #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .i_flush     (branch_mispredict),
            .i_push      (w_push[gi]),
            .i_push_pkt  (w_push_pkt[gi]),
            .i_pop       (w_pop[gi]),
            .o_head      (w_head[gi]),
            .o_count     (w_count[gi]),
            .o_not_full  (w_not_full[gi]),
            .o_not_empty (w_not_empty[gi])
        );
    end

    // Round-robin search from r_rr_ptr upward (mod N_SRC); requests come from
    // FIFO heads only, so a result never bypasses its FIFO.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand_sum  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_cand_sum = {1'b0, r_rr_ptr} + (RRW+1)'(k);
            if (w_cand_sum >= (RRW+1)'(N_SRC)) begin
                w_cand_sum = w_cand_sum - (RRW+1)'(N_SRC);
            end
            if (!w_gnt_valid && w_not_empty[w_cand_sum[RRW-1:0]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand_sum[RRW-1:0];
            end
        end
    end

    assign w_gnt_pkt = w_head[w_gnt_idx];
    assign w_rr_next = (w_gnt_idx == RRW'(N_SRC - 1)) ? '0 : w_gnt_idx + RRW'(1);

    // A flush kills this cycle's grant (the FIFOs discard the pop too) but
    // keeps the rr pointer; only reset returns it to source 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_pkt   <= '0;
            r_rr_ptr    <= '0;
        end else if (branch_mispredict) begin
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_cdb_pkt <= w_gnt_pkt;
                r_rr_ptr  <= w_rr_next;
            end
        end
    end

    assign o_cdb_valid   = r_cdb_valid;
    assign o_cdb_prd     = r_cdb_pkt.prd;
    assign o_cdb_rob_tag = r_cdb_pkt.rob_tag;
    assign o_cdb_data    = r_cdb_pkt.data;
    assign o_cdb_rf_we   = r_cdb_valid && (r_cdb_pkt.prd != '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a queue-based reference model is stepped on every
// rising edge and one compare process checks every output on the falling
// edge; directed scenarios add literal expectations on top.
module tb_cdb_arbiter;

    localparam int PW    = 7;
    localparam int RW    = 4;
    localparam int NS    = 3;
    localparam int DEPTH = 2;
    localparam int PKW   = PW + RW + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              branch_mispredict;
    logic [NS-1:0]     src_valid;
    logic [NS*PW-1:0]  src_prd;
    logic [NS*RW-1:0]  src_tag;
    logic [NS*32-1:0]  src_data;
    logic [NS-1:0]     o_src_ready;
    logic              o_cdb_valid;
    logic [PW-1:0]     o_cdb_prd;
    logic [RW-1:0]     o_cdb_rob_tag;
    logic [31:0]       o_cdb_data;
    logic              o_cdb_rf_we;

    cdb_arbiter #(
        .PREG_WIDTH (PW),
        .ROB_WIDTH  (RW),
        .N_SRC      (NS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_src_valid       (src_valid),
        .i_src_prd         (src_prd),
        .i_src_rob_tag     (src_tag),
        .i_src_data        (src_data),
        .o_src_ready       (o_src_ready),
        .o_cdb_valid       (o_cdb_valid),
        .o_cdb_prd         (o_cdb_prd),
        .o_cdb_rob_tag     (o_cdb_rob_tag),
        .o_cdb_data        (o_cdb_data),
        .o_cdb_rf_we       (o_cdb_rf_we),
        .branch_mispredict (branch_mispredict)
    );

    // ---------------- reference model ----------------
    logic [PKW-1:0] exp_q [NS][$];
    int             m_rr;
    logic           m_valid;
    logic [PKW-1:0] m_pkt;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    logic [NS-1:0] hs;
    int   bc [4];

    function automatic logic [PKW-1:0] src_pkt(int s);
        return {src_prd[s*PW +: PW], src_tag[s*RW +: RW], src_data[s*32 +: 32]};
    endfunction

    function automatic logic [NS-1:0] model_ready();
        logic [NS-1:0] r;
        for (int s = 0; s < NS; s++) r[s] = (exp_q[s].size() != DEPTH);
        return r;
    endfunction

    task automatic model_step();
        logic [NS-1:0] rdy;
        int g;
        int s;
        if (reset) begin
            for (int i = 0; i < NS; i++) exp_q[i].delete();
            m_rr    = 0;
            m_valid = 1'b0;
            m_pkt   = '0;
        end else if (branch_mispredict) begin
            for (int i = 0; i < NS; i++) exp_q[i].delete();
            m_valid = 1'b0;
        end else begin
            rdy = model_ready();
            g = -1;
            for (int k = 0; k < NS; k++) begin
                s = (m_rr + k) % NS;
                if (g < 0 && exp_q[s].size() > 0) g = s;
            end
            if (g >= 0) begin
                m_pkt   = exp_q[g].pop_front();
                m_valid = 1'b1;
                m_rr    = (g + 1) % NS;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NS; i++)
                if (src_valid[i] && rdy[i]) exp_q[i].push_back(src_pkt(i));
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cdb_valid", o_cdb_valid, m_valid);
            if (m_valid) begin
                chk("cdb_prd",  o_cdb_prd,     m_pkt[PKW-1 -: PW]);
                chk("cdb_tag",  o_cdb_rob_tag, m_pkt[32 +: RW]);
                chk("cdb_data", o_cdb_data,    m_pkt[31:0]);
            end
            chk("rf_we", o_cdb_rf_we, m_valid && (m_pkt[PKW-1 -: PW] != '0));
            chk("src_ready", o_src_ready, model_ready());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        hs = src_valid & o_src_ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_src(int s, logic [PW-1:0] prd, logic [RW-1:0] tag, logic [31:0] data);
        src_valid[s]            = 1'b1;
        src_prd[s*PW +: PW]     = prd;
        src_tag[s*RW +: RW]     = tag;
        src_data[s*32 +: 32]    = data;
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    // A source holds its result until accepted, then offers a new one with
    // probability pct; the data top bits carry the source index.
    task automatic refresh(int pct);
        logic [PW-1:0] prd;
        for (int s = 0; s < NS; s++) begin
            if (!src_valid[s] || hs[s]) begin
                prd = ($urandom_range(7) == 0) ? '0 : PW'($urandom_range(127));
                set_src(s, prd, RW'($urandom_range(15)),
                        {2'(s), 30'($urandom_range(32'h3fff_ffff))});
                src_valid[s] = ($urandom_range(99) < pct);
            end
        end
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int pct;
        reset = 1'b1;
        branch_mispredict = 1'b0;
        src_valid = '0;
        src_prd = '0;
        src_tag = '0;
        src_data = '0;
        hs = '0;
        cycle();
        cycle();
        chk_en = 1'b1;
        chk("reset_valid", o_cdb_valid, 1'b0);
        chk("reset_rf_we", o_cdb_rf_we, 1'b0);
        chk("reset_prd",   o_cdb_prd, 0);
        chk("reset_tag",   o_cdb_rob_tag, 0);
        chk("reset_data",  o_cdb_data, 0);
        chk("reset_ready", o_src_ready, 3'b111);
        reset = 1'b0;

        // Single ALU result: visible two edges after the push, gone one later.
        set_src(0, 7'd5, 4'd3, 32'hDEAD_BEEF);
        cycle();
        idle();
        cycle();
        chk("single_valid", o_cdb_valid, 1'b1);
        chk("single_prd",   o_cdb_prd, 5);
        chk("single_tag",   o_cdb_rob_tag, 3);
        chk("single_data",  o_cdb_data, 32'hDEAD_BEEF);
        chk("single_rf_we", o_cdb_rf_we, 1'b1);
        cycle();
        chk("single_after", o_cdb_valid, 1'b0);

        // Three-way contention from rr_ptr=0: ALU, BR, LSU, then rr back at 0.
        pulse_reset();
        set_src(0, 7'd10, 4'd1, 32'h0A0A_0001);
        set_src(1, 7'd11, 4'd2, 32'h0B0B_0002);
        set_src(2, 7'd12, 4'd3, 32'h0C0C_0003);
        cycle();
        idle();
        cycle();
        chk("rr_first_alu",  o_cdb_data, 32'h0A0A_0001);
        cycle();
        chk("rr_second_br",  o_cdb_data, 32'h0B0B_0002);
        cycle();
        chk("rr_third_lsu",  o_cdb_data, 32'h0C0C_0003);
        cycle();
        chk("rr_drained",    o_cdb_valid, 1'b0);
        set_src(0, 7'd20, 4'd4, 32'h1111_0001);
        set_src(1, 7'd21, 4'd5, 32'h2222_0002);
        set_src(2, 7'd22, 4'd6, 32'h3333_0003);
        cycle();
        idle();
        cycle();
        chk("rr_wrap_alu", o_cdb_data, 32'h1111_0001);
        repeat (3) cycle();

        // prd=0 result: broadcast but no regfile write.
        set_src(1, 7'd0, 4'd7, 32'h0000_BEEF);
        cycle();
        idle();
        cycle();
        chk("prd0_valid", o_cdb_valid, 1'b1);
        chk("prd0_rf_we", o_cdb_rf_we, 1'b0);
        chk("prd0_tag",   o_cdb_rob_tag, 7);
        cycle();

        // Reset with two entries queued (rr_ptr is 2 at this point).
        set_src(0, 7'd30, 4'd8, 32'h5555_0000);
        set_src(1, 7'd31, 4'd9, 32'h6666_0000);
        cycle();
        idle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_valid", o_cdb_valid, 1'b0);
        chk("rst_mid_rf_we", o_cdb_rf_we, 1'b0);
        chk("rst_mid_prd",   o_cdb_prd, 0);
        chk("rst_mid_tag",   o_cdb_rob_tag, 0);
        chk("rst_mid_data",  o_cdb_data, 0);
        chk("rst_mid_ready", o_src_ready, 3'b111);
        reset = 1'b0;
        set_src(0, 7'd40, 4'd1, 32'h7777_0000);
        set_src(1, 7'd41, 4'd2, 32'h8888_0000);
        set_src(2, 7'd42, 4'd3, 32'h9999_0000);
        cycle();
        idle();
        cycle();
        chk("rst_rr_zero", o_cdb_data, 32'h7777_0000);
        repeat (3) cycle();

        // Flush with 4 results buffered and one on the CDB.
        set_src(0, 7'd50, 4'd1, 32'hAAAA_0001);
        set_src(1, 7'd51, 4'd2, 32'hBBBB_0001);
        set_src(2, 7'd52, 4'd3, 32'hCCCC_0001);
        cycle();
        idle();
        set_src(0, 7'd53, 4'd4, 32'hAAAA_0002);
        set_src(1, 7'd54, 4'd5, 32'hBBBB_0002);
        cycle();
        idle();
        chk("flush_cur_bcast", o_cdb_data, 32'hAAAA_0001);
        branch_mispredict = 1'b1;
        cycle();
        branch_mispredict = 1'b0;
        chk("flush_valid", o_cdb_valid, 1'b0);
        chk("flush_ready", o_src_ready, 3'b111);
        seen = 0;
        repeat (6) begin
            cycle();
            if (o_cdb_valid) seen++;
        end
        chk("flush_no_bcast", seen, 0);

        // Saturation: LSU fills after two pushes, then strict 1-in-3 share.
        pulse_reset();
        refresh(100);
        cycle();
        refresh(100);
        cycle();
        refresh(100);
        chk("bp_lsu_ready", o_src_ready[2], 1'b0);
        repeat (20) begin
            cycle();
            refresh(100);
        end
        for (int i = 0; i < 4; i++) bc[i] = 0;
        repeat (30) begin
            cycle();
            refresh(100);
            if (o_cdb_valid) bc[o_cdb_data[31:30]]++;
        end
        chk("bp_total", bc[0] + bc[1] + bc[2], 30);
        chk("bp_lsu_share", bc[2], 10);

        // Random traffic with occasional flush and reset.
        for (int ph = 0; ph < 6; ph++) begin
            pct = $urandom_range(90, 20);
            repeat (500) begin
                refresh(pct);
                branch_mispredict = ($urandom_range(63) == 0);
                reset = ($urandom_range(255) == 0);
                cycle();
            end
        end
        branch_mispredict = 1'b0;
        reset = 1'b0;
        idle();
        repeat (10) cycle();
        chk("final_drained", o_cdb_valid, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
